// File: rtl/cmp_pkg.sv
// Shared types and defaults for the comparator result monitor.
package cmp_pkg;

   localparam int CMP_CNT_W = 8;

   typedef enum logic [1:0] {
      RES_NONE = 2'd0,
      RES_GT   = 2'd1,
      RES_LT   = 2'd2,
      RES_EQ   = 2'd3
   } res_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_COUNT = 2'd1,
      S_LOCK  = 2'd2
   } run_state_e;

   // True when exactly one of the three comparator flags is set.
   function automatic logic is_onehot3(input logic [2:0] flags);
      return (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and synchronous clear.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (inc && (cnt != {W{1'b1}})) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/cmp_result_monitor.sv
// Counts comparator outcomes and detects a run of RUN_LEN equal results.
// Define CMP_ONEHOT_CHECK_EN to add err_sticky/err_cnt for malformed samples.
module cmp_result_monitor
   import cmp_pkg::*;
#(
   parameter int CNT_W   = CMP_CNT_W,
   parameter int RUN_LEN = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             a_grt_b,
   input  logic             a_less_b,
   input  logic             a_eq_b,
   input  logic             clear,
   output logic [CNT_W-1:0] gt_cnt,
   output logic [CNT_W-1:0] lt_cnt,
   output logic [CNT_W-1:0] eq_cnt,
   output logic [1:0]       last_res,
   output logic             match,
   output logic             match_pulse
`ifdef CMP_ONEHOT_CHECK_EN
   ,
   output logic             err_sticky,
   output logic [CNT_W-1:0] err_cnt
`endif
);

   localparam logic [3:0] RUN_LEN_C = 4'(RUN_LEN);

   logic       onehot;
   logic       accepted;
   logic       malformed;
   logic       acc_gt;
   logic       acc_lt;
   logic       acc_eq;
   res_e       res_in;
   run_state_e state;
   logic [3:0] run_cnt;
   logic [3:0] run_cnt_nxt;

   assign onehot      = is_onehot3({a_grt_b, a_less_b, a_eq_b});
   assign accepted    = in_valid && onehot;
   assign malformed   = in_valid && !onehot;
   assign acc_gt      = accepted && a_grt_b;
   assign acc_lt      = accepted && a_less_b;
   assign acc_eq      = accepted && a_eq_b;
   assign run_cnt_nxt = run_cnt + 4'd1;

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      res_in = RES_NONE;
      if (acc_gt)      res_in = RES_GT;
      else if (acc_lt) res_in = RES_LT;
      else if (acc_eq) res_in = RES_EQ;
   end

   sat_counter #(.W(CNT_W)) u_gt_cnt (.clk(clk), .rst(rst), .clr(clear), .inc(acc_gt), .cnt(gt_cnt));
   sat_counter #(.W(CNT_W)) u_lt_cnt (.clk(clk), .rst(rst), .clr(clear), .inc(acc_lt), .cnt(lt_cnt));
   sat_counter #(.W(CNT_W)) u_eq_cnt (.clk(clk), .rst(rst), .clr(clear), .inc(acc_eq), .cnt(eq_cnt));

   // last_res survives clear; only rst returns it to RES_NONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_res <= RES_NONE;
      end else if (!clear && accepted) begin
         last_res <= res_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         state       <= S_IDLE;
         run_cnt     <= 4'd0;
         match       <= 1'b0;
         match_pulse <= 1'b0;
      end else begin
         match_pulse <= 1'b0;
         case (state)
            S_IDLE: begin
               if (acc_eq) begin
                  state   <= S_COUNT;
                  run_cnt <= 4'd1;
               end
            end
            S_COUNT: begin
               if (acc_eq) begin
                  run_cnt <= run_cnt_nxt;
                  if (run_cnt_nxt == RUN_LEN_C) begin
                     state       <= S_LOCK;
                     match       <= 1'b1;
                     match_pulse <= 1'b1;
                  end
               end else if (accepted) begin
                  state   <= S_IDLE;
                  run_cnt <= 4'd0;
               end
            end
            S_LOCK: begin
               if (accepted && !acc_eq) begin
                  state   <= S_IDLE;
                  run_cnt <= 4'd0;
                  match   <= 1'b0;
               end
            end
            default: begin
               state   <= S_IDLE;
               run_cnt <= 4'd0;
               match   <= 1'b0;
            end
         endcase
      end
   end

`ifdef CMP_ONEHOT_CHECK_EN
   sat_counter #(.W(CNT_W)) u_err_cnt (.clk(clk), .rst(rst), .clr(clear), .inc(malformed), .cnt(err_cnt));

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         err_sticky <= 1'b0;
      end else if (malformed) begin
         err_sticky <= 1'b1;
      end
   end
`else
   logic unused_malformed;
   assign unused_malformed = malformed;
`endif

endmodule

// File: doc/cmp_result_monitor.md
Name: cmp_result_monitor

Overview:
- Sits directly downstream of the 4-bit magnitude comparator and consumes its three one-hot result flags (greater, less, equal) with a valid strobe.
- Keeps saturating per-outcome counts and detects a run of RUN_LEN consecutive "equal" results.
- Reports the last outcome seen.
- Used by test and monitor logic to qualify comparator streams without a CPU.

Parameters:
- CNT_W, 8, width of each outcome counter (counts saturate at 2^CNT_W-1)
- RUN_LEN, 4, number of consecutive valid equal results that raises match (legal range 2..15)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  flags below are sampled this cycle
- a_grt_b  input  1  comparator greater flag
- a_less_b  input  1  comparator less flag
- a_eq_b  input  1  comparator equal flag
- clear  input  1  synchronous clear of counters and run FSM
- gt_cnt  output  CNT_W  count of accepted greater results
- lt_cnt  output  CNT_W  count of accepted less results
- eq_cnt  output  CNT_W  count of accepted equal results
- last_res  output  2  last accepted outcome: 0 none, 1 gt, 2 lt, 3 eq
- match  output  1  level; high while the equal run is at or beyond RUN_LEN
- match_pulse  output  1  one-cycle pulse on the cycle match rises

Behaviour:
- Reset (rst=1 at posedge): all counters 0, last_res=0, match=0, match_pulse=0, FSM=IDLE.
- rst has priority over clear. clear has priority over in_valid in the same cycle: the sample is dropped.
- Accepted sample: in_valid=1 and exactly one flag high.
- Latency: all outputs are registered and reflect an accepted sample on the next clock edge (1 cycle).
- Counters:
  - Increment by 1 on the matching accepted sample.
  - Hold at all-ones; never wrap.
  - Only one counter changes per cycle.
- in_valid=0: no state changes; match_pulse deasserts.
- Run FSM, run_cnt is 4-bit:
  - IDLE:
    - accepted eq -> COUNT, run_cnt=1.
    - Else stay.
  - COUNT:
    - accepted eq -> run_cnt+1. If the new value equals RUN_LEN -> LOCK, match=1, match_pulse=1.
    - accepted gt/lt -> IDLE, run_cnt=0.
  - LOCK:
    - accepted eq -> stay, match held, no new pulse.
    - accepted gt/lt -> IDLE, match=0 the following cycle.
  - Invalid cycles (in_valid=0) do not break a run.
  - clear -> IDLE, match=0, run_cnt=0, counters=0; last_res is kept.
- Malformed sample: in_valid=1 with zero or more than one flag high.
  - Ignored entirely: no counter, last_res or FSM change.
  - See the optional feature for how it is reported.

Optional Feature:
- Macro: CMP_ONEHOT_CHECK_EN.
- When defined:
  - Adds output err_sticky (1 bit, reset 0).
  - err_sticky sets on any malformed sample and clears only on rst or clear.
  - Adds output err_cnt (CNT_W bits, saturating), which counts malformed samples.
- When undefined:
  - Neither port exists.
  - Malformed samples are still silently ignored.

Decomposition:
- Package cmp_pkg holds:
  - res_e enum (RES_NONE=0, RES_GT=1, RES_LT=2, RES_EQ=3).
  - run FSM state enum (S_IDLE, S_COUNT, S_LOCK).
  - Default width constant CMP_CNT_W=8.
- One natural sub-module: sat_counter (parameter W; inputs clk, rst, clr, inc; output cnt).
  - Instantiated three times, plus once for err_cnt.

Test Plan:
- Reset then idle: rst high 2 cycles, then 5 cycles in_valid=0 -> all counts 0, last_res=0, match=0.
- Mixed stream: gt, lt, eq, gt (in_valid=1 each cycle) -> gt_cnt=2, lt_cnt=1, eq_cnt=1, last_res=1; match never rises.
- Equal run, RUN_LEN=4:
  - eq x4 with one in_valid=0 gap inserted -> match_pulse for exactly 1 cycle one edge after the 4th eq, and match stays high.
  - A 5th eq keeps match high with no second pulse.
  - Then gt -> match=0 one cycle later.
- Saturation, CNT_W=3: 10 consecutive gt -> gt_cnt stops at 7 and does not wrap.
- Priority:
  - clear together with a valid eq -> counters 0, the eq is dropped, FSM IDLE.
  - rst asserted in the middle of a run (run_cnt=3) -> next eq starts a fresh run, run_cnt=1.
- Malformed input, with CMP_ONEHOT_CHECK_EN defined: in_valid=1 with gt=1 and eq=1 -> counters unchanged, err_sticky=1, err_cnt=1; clear -> err_sticky=0.
